// File: rtl/ex_flag_stage_pkg.sv
// Shared encodings and constants for the EX flag stage.
package ex_flag_stage_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CLASS_W = 2;
  localparam int unsigned CCC_W   = 3;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [CLASS_W-1:0] {
    OP_PASS  = 2'b00,
    OP_ARITH = 2'b01,
    OP_LOGIC = 2'b10,
    OP_RSVD  = 2'b11
  } op_class_e;

  typedef enum logic [CCC_W-1:0] {
    CC_NZ = 3'b000,  // ~Z
    CC_Z  = 3'b001,  // Z
    CC_GT = 3'b010,  // ~Z & ~N
    CC_LT = 3'b011,  // N
    CC_GE = 3'b100,  // Z | (~Z & ~N)
    CC_LE = 3'b101,  // N | Z
    CC_V  = 3'b110,  // V
    CC_AL = 3'b111   // always
  } ccc_e;

endpackage

// File: rtl/ex_flag_stage_br_cond.sv
// Branch condition evaluation from a flag set and a condition code.
module br_cond
  import ex_flag_stage_pkg::*;
(
  input  logic [CCC_W-1:0] ccc,
  input  logic             Z,
  input  logic             V,
  input  logic             N,
  output logic             Br_taken
);

  // Decode the condition code against the supplied flags.
  always_comb begin
    Br_taken = 1'b0;
    case (ccc_e'(ccc))
      CC_NZ:   Br_taken = ~Z;
      CC_Z:    Br_taken = Z;
      CC_GT:   Br_taken = ~Z & ~N;
      CC_LT:   Br_taken = N;
      CC_GE:   Br_taken = Z | (~Z & ~N);
      CC_LE:   Br_taken = N | Z;
      CC_V:    Br_taken = V;
      CC_AL:   Br_taken = 1'b1;
      default: Br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX flag stage: saturates adder results, registers Z/V/N, evaluates branches.
// Optional build macro FLAG_BYPASS_EN forwards same-cycle flag updates to br_cond.
module ex_flag_stage
  import ex_flag_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] op_class,
  input  logic [DATA_W-1:0]  Sum,
  input  logic               pos_Ovfl,
  input  logic               neg_Ovfl,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  Result,
  output logic               Z,
  output logic               V,
  output logic               N,
  input  logic [CCC_W-1:0]   ccc,
  output logic               Br_taken
);

  logic              xfer;
  logic [DATA_W-1:0] sat;
  logic              z_nxt;
  logic              v_nxt;
  logic              n_nxt;
  logic              br_z;
  logic              br_v;
  logic              br_n;

  assign in_ready = ~out_valid | out_ready;
  assign xfer     = in_valid & in_ready & ~flush;

  // Saturated result and the flag values a transfer this cycle would write.
  always_comb begin
    sat   = Sum;
    z_nxt = Z;
    v_nxt = V;
    n_nxt = N;
    if (op_class_e'(op_class) == OP_ARITH) begin
      if (pos_Ovfl)      sat = SAT_POS;  // pos wins when both are flagged
      else if (neg_Ovfl) sat = SAT_NEG;
    end
    if (xfer) begin
      case (op_class_e'(op_class))
        OP_ARITH: begin
          z_nxt = (sat == '0);
          v_nxt = pos_Ovfl | neg_Ovfl;
          n_nxt = sat[DATA_W-1];
        end
        OP_LOGIC: z_nxt = (Sum == '0);
        default: ;
      endcase
    end
  end

  // Output register, valid tracking and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Result    <= '0;
      Z         <= 1'b0;
      V         <= 1'b0;
      N         <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      Result    <= sat;
      Z         <= z_nxt;
      V         <= v_nxt;
      N         <= n_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FLAG_BYPASS_EN
  // z/v/n_nxt equal the registered flags whenever no transfer occurs.
  assign br_z = z_nxt;
  assign br_v = v_nxt;
  assign br_n = n_nxt;
`else
  assign br_z = Z;
  assign br_v = V;
  assign br_n = N;
`endif

  br_cond u_br_cond (
    .ccc      (ccc),
    .Z        (br_z),
    .V        (br_v),
    .N        (br_n),
    .Br_taken (Br_taken)
  );

endmodule

// File: tb/tb_ex_flag_stage.sv
// Self-checking bench for ex_flag_stage: vector table, corner sequences, random vs model.
module tb_ex_flag_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op_class;
  logic [15:0] Sum;
  logic        pos_Ovfl;
  logic        neg_Ovfl;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Result;
  logic        Z, V, N;
  logic [2:0]  ccc;
  logic        Br_taken;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic        m_valid, m_z, m_v, m_n;
  logic [15:0] m_result;

  ex_flag_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .Sum(Sum), .pos_Ovfl(pos_Ovfl), .neg_Ovfl(neg_Ovfl),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .Z(Z), .V(V), .N(N), .ccc(ccc), .Br_taken(Br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition table indexed by ccc: bit k is the outcome of code k.
  function automatic logic ref_br(input logic [2:0] cc, input logic z, input logic v, input logic n);
    logic [7:0] outcomes;
    logic signed_ge0;
    signed_ge0 = ~n;  // result non-negative
    outcomes = {1'b1, v, n | z, z | signed_ge0, n, signed_ge0 & ~z, z, ~z};
    return outcomes[cc];
  endfunction

  // Saturation as clamping: overflow picks the nearest representable extreme.
  function automatic logic [15:0] ref_sat(input logic [1:0] oc, input logic [15:0] s,
                                          input logic p, input logic ng);
    if (oc != 2'd1) return s;
    if (p)          return 16'd32767;
    if (ng)         return 16'd32768;
    return s;
  endfunction

  // Flags the model would hold after accepting (oc, s, p, ng).
  task automatic ref_flags(input logic [1:0] oc, input logic [15:0] s, input logic p,
                           input logic ng, output logic z, output logic v, output logic n);
    logic [15:0] r;
    r = ref_sat(oc, s, p, ng);
    z = m_z; v = m_v; n = m_n;
    if (oc == 2'd1) begin
      z = (r == 16'd0); v = p | ng; n = (r >= 16'd32768);
    end else if (oc == 2'd2) begin
      z = (s == 16'd0);
    end
  endtask

  // Apply one cycle of inputs, check combinational then registered outputs against the model.
  task automatic step(input logic r, input logic iv, input logic [1:0] oc, input logic [15:0] s,
                      input logic p, input logic ng, input logic fl, input logic ordy,
                      input logic [2:0] cc);
    logic acc, fz, fv, fn, exp_br;
    rst = r; in_valid = iv; op_class = oc; Sum = s; pos_Ovfl = p; neg_Ovfl = ng;
    flush = fl; out_ready = ordy; ccc = cc;
    #1;
    acc = iv && (!m_valid || ordy) && !fl;
    chk("in_ready_pre", 16'(in_ready), 16'(!m_valid || ordy));
    ref_flags(oc, s, p, ng, fz, fv, fn);
`ifdef FLAG_BYPASS_EN
    if (acc) exp_br = ref_br(cc, fz, fv, fn);
    else     exp_br = ref_br(cc, m_z, m_v, m_n);
`else
    exp_br = ref_br(cc, m_z, m_v, m_n);
`endif
    chk("br_taken", 16'(Br_taken), 16'(exp_br));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_result = 0; m_z = 0; m_v = 0; m_n = 0;
    end else if (fl) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1; m_result = ref_sat(oc, s, p, ng);
      m_z = fz; m_v = fv; m_n = fn;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", 16'(out_valid), 16'(m_valid));
    chk("result", Result, m_result);
    chk("z", 16'(Z), 16'(m_z));
    chk("v", 16'(V), 16'(m_v));
    chk("n", 16'(N), 16'(m_n));
  endtask

  typedef struct {
    logic        r, iv;
    logic [1:0]  oc;
    logic [15:0] s;
    logic        p, ng, fl, ordy;
    logic [2:0]  cc;
    logic        ev;
    logic [15:0] er;
    logic        ez, evf, en, eb;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // r iv oc s p ng fl ordy cc | valid result z v n br
    vecs[0]  = '{1,0,2'd0,16'h0000,0,0,0,1,3'b000, 0,16'h0000,0,0,0,1};
    vecs[1]  = '{0,1,2'd1,16'h8003,1,0,0,1,3'b110, 1,16'h7FFF,0,1,0,1};
    vecs[2]  = '{0,1,2'd1,16'h0000,0,0,0,1,3'b001, 1,16'h0000,1,0,0,1};
    vecs[3]  = '{0,0,2'd1,16'hAAAA,0,0,0,1,3'b000, 0,16'h0000,1,0,0,0};
    vecs[4]  = '{0,1,2'd1,16'h7FFF,0,1,0,1,3'b011, 1,16'h8000,0,1,1,1};
    vecs[5]  = '{0,1,2'd2,16'h0000,0,0,0,1,3'b101, 1,16'h0000,1,1,1,1};
    vecs[6]  = '{0,1,2'd0,16'h1234,1,0,0,1,3'b010, 1,16'h1234,1,1,1,0};
    vecs[7]  = '{0,1,2'd3,16'h0000,0,1,0,1,3'b100, 1,16'h0000,1,1,1,1};
    vecs[8]  = '{0,1,2'd1,16'h0001,1,1,0,1,3'b100, 1,16'h7FFF,0,1,0,1};
    vecs[9]  = '{0,1,2'd1,16'h0000,0,1,1,1,3'b000, 0,16'h7FFF,0,1,0,1};
    vecs[10] = '{0,1,2'd1,16'h8000,0,0,0,1,3'b010, 1,16'h8000,0,0,1,0};
    vecs[11] = '{1,1,2'd1,16'h4444,1,0,1,1,3'b111, 0,16'h0000,0,0,0,1};

    // bring-up reset before any comparison
    rst = 1; in_valid = 0; op_class = 0; Sum = 0; pos_Ovfl = 0; neg_Ovfl = 0;
    flush = 0; out_ready = 0; ccc = 0;
    m_valid = 0; m_result = 0; m_z = 0; m_v = 0; m_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 16'(out_valid), 16'd0);
    chk("reset_in_ready", 16'(in_ready), 16'd1);

    // directed table
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r, vecs[i].iv, vecs[i].oc, vecs[i].s, vecs[i].p, vecs[i].ng,
           vecs[i].fl, vecs[i].ordy, vecs[i].cc);
      chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].ev));
      chk($sformatf("vec%0d_result", i), Result, vecs[i].er);
      chk($sformatf("vec%0d_flags", i), 16'({Z, V, N}), 16'({vecs[i].ez, vecs[i].evf, vecs[i].en}));
      rst = 0; in_valid = 0;
      #1;
      chk($sformatf("vec%0d_br", i), 16'(Br_taken), 16'(vecs[i].eb));
    end

    // backpressure: held result, in_ready low until downstream drains
    step(0, 1, 2'd1, 16'h0042, 0, 0, 0, 0, 3'b000);
    chk("bp_load", Result, 16'h0042);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 2'd1, 16'h0099, 0, 0, 0, 0, 3'b000);
      chk("bp_in_ready", 16'(in_ready), 16'd0);
      chk("bp_hold", Result, 16'h0042);
      chk("bp_valid", 16'(out_valid), 16'd1);
    end
    step(0, 1, 2'd1, 16'h0099, 0, 0, 0, 1, 3'b000);
    chk("bp_accept", Result, 16'h0099);

    // reset while stalled drops the held result
    step(0, 1, 2'd1, 16'h0055, 0, 0, 0, 0, 3'b000);
    chk("stall_hold", Result, 16'h0099);
    step(1, 1, 2'd1, 16'h0055, 1, 0, 0, 0, 3'b000);
    chk("rst_stall_out", 16'({out_valid, Z, V, N}), 16'd0);
    chk("rst_stall_result", Result, 16'h0000);
    chk("rst_stall_in_ready", 16'(in_ready), 16'd1);

    // same-cycle zero result vs registered Z=0
    step(0, 1, 2'd1, 16'h0005, 0, 0, 0, 1, 3'b001);
    rst = 0; in_valid = 1; op_class = 2'd1; Sum = 16'h0000; pos_Ovfl = 0; neg_Ovfl = 0;
    flush = 0; out_ready = 1; ccc = 3'b001;
    #1;
`ifdef FLAG_BYPASS_EN
    chk("bypass_br", 16'(Br_taken), 16'd1);
`else
    chk("bypass_br", 16'(Br_taken), 16'd0);
`endif
    step(0, 1, 2'd1, 16'h0000, 0, 0, 0, 1, 3'b001);
    chk("zero_z", 16'(Z), 16'd1);

    // randomized traffic against the model
    for (int t = 0; t < 400; t++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), s,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
           3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
